// File: rtl/uart_word_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port
// that the word loader sits between.
interface uart_word_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_break;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        output rx_valid, rx_data, rx_break,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_break,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_word_loader.sv
// Assembles UART bytes little-endian into words and writes them to consecutive
// instruction-memory addresses; ends on a terminator word or full memory.
module uart_word_loader #(
    parameter int                      WORD_BYTES  = 4,
    parameter int                      ADDR_W      = 8,
    parameter int                      DEPTH       = 256,
    parameter int                      TERM_EN     = 1,
    parameter logic [8*WORD_BYTES-1:0] TERM_WORD   = {WORD_BYTES{8'hFF}},
    parameter int                      TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_en,
    uart_word_loader_if.slave bus,
    output logic              write_done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic              busy
);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int BW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [BW-1:0]   LAST_IDX  = BW'(WORD_BYTES - 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t            state;
    logic [BW-1:0]     byte_idx;
    logic [TW-1:0]     tmo_cnt;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] full_word;
    logic [ADDR_W-1:0] ptr;
    logic              is_last;
    logic              tmo_hit;

    // Word as it would look with the current byte merged into its lane.
    always_comb begin
        full_word = asm_word;
        full_word[{byte_idx, 3'b000} +: 8] = bus.rx_data;
    end

    assign is_last = (byte_idx == LAST_IDX);
    assign tmo_hit = (TIMEOUT_CYC > 0) && (byte_idx != '0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            byte_idx      <= '0;
            tmo_cnt       <= '0;
            asm_word      <= '0;
            ptr           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            write_done    <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            word_count    <= '0;
            busy          <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        word_count <= '0;
                        ptr        <= '0;
                        byte_idx   <= '0;
                        tmo_cnt    <= '0;
                        asm_word   <= '0;
                        error      <= 1'b0;
                        err_code   <= 2'd0;
                        write_done <= 1'b0;
                    end
                end
                LOAD: begin
                    // Priority: abort, break, full memory, timeout, byte capture.
                    if (!load_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.rx_break) begin
                        state    <= ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (word_count == DEPTH_CNT) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        write_done <= 1'b1;
                    end else if (tmo_hit) begin
                        state    <= ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= 2'd2;
                    end else if (bus.rx_valid) begin
                        tmo_cnt  <= '0;
                        asm_word <= full_word;
                        if (is_last) begin
                            byte_idx <= '0;
                            if ((TERM_EN != 0) && (full_word == TERM_WORD)) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                write_done <= 1'b1;
                            end else begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= ptr;
                                bus.mem_wdata <= full_word;
                                ptr           <= ptr + 1'b1;
                                word_count    <= word_count + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (byte_idx != '0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    if (!load_en) begin
                        state      <= IDLE;
                        write_done <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench: three loader configurations, table-driven byte vectors,
// a write scoreboard per instance and hand sequences for timeout/break/abort/reset.
module tb_uart_word_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic le0, le1, le2;
    logic wd0, wd1, wd2, er0, er1, er2, bz0, bz1, bz2;
    logic [1:0] ec0, ec1, ec2;
    logic [8:0] wc0, wc1, wc2;

    uart_word_loader_if #(.ADDR_W(8), .WORD_W(32)) b0 ();
    uart_word_loader_if #(.ADDR_W(8), .WORD_W(32)) b1 ();
    uart_word_loader_if #(.ADDR_W(8), .WORD_W(16)) b2 ();

    uart_word_loader #(.WORD_BYTES(4), .ADDR_W(8), .DEPTH(256), .TERM_EN(1),
                       .TERM_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(100)) u0 (
        .clk(clk), .resetn(resetn), .load_en(le0), .bus(b0),
        .write_done(wd0), .error(er0), .err_code(ec0), .word_count(wc0), .busy(bz0));

    uart_word_loader #(.WORD_BYTES(4), .ADDR_W(8), .DEPTH(4), .TERM_EN(0),
                       .TERM_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(0)) u1 (
        .clk(clk), .resetn(resetn), .load_en(le1), .bus(b1),
        .write_done(wd1), .error(er1), .err_code(ec1), .word_count(wc1), .busy(bz1));

    uart_word_loader #(.WORD_BYTES(2), .ADDR_W(8), .DEPTH(256), .TERM_EN(1),
                       .TERM_WORD(16'hFFFF), .TIMEOUT_CYC(0)) u2 (
        .clk(clk), .resetn(resetn), .load_en(le2), .bus(b2),
        .write_done(wd2), .error(er2), .err_code(ec2), .word_count(wc2), .busy(bz2));

    int nchk = 0;
    int nerr = 0;

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    wr_t q0[$], q1[$], q2[$];

    typedef struct {
        int          d;
        logic [7:0]  b;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int d, input logic [7:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input logic [7:0] a, input logic [31:0] w);
        wr_t e;
        int  n;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        nchk++;
        if (n == 0) begin
            nerr++;
            $display("FAIL wr%0d_unexpected: got write addr=%h data=%h, expected no write", d, a, w);
        end else begin
            case (d)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if (a !== e.addr || w !== e.data) begin
                nerr++;
                $display("FAIL wr%0d_data: got addr=%h data=%h, expected addr=%h data=%h",
                         d, a, w, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) if (b0.mem_we === 1'b1) mon(0, b0.mem_addr, b0.mem_wdata);
    always @(negedge clk) if (b1.mem_we === 1'b1) mon(1, b1.mem_addr, b1.mem_wdata);
    always @(negedge clk) if (b2.mem_we === 1'b1) mon(2, b2.mem_addr, {16'h0, b2.mem_wdata});

    function automatic logic we_of(input int d);
        case (d)
            0: return b0.mem_we;
            1: return b1.mem_we;
            default: return b2.mem_we;
        endcase
    endfunction

    task automatic clear_rx();
        b0.rx_valid = 1'b0; b0.rx_break = 1'b0; b0.rx_data = '0;
        b1.rx_valid = 1'b0; b1.rx_break = 1'b0; b1.rx_data = '0;
        b2.rx_valid = 1'b0; b2.rx_break = 1'b0; b2.rx_data = '0;
    endtask

    // One-cycle strobe; returns 1 time unit after the capturing edge.
    task automatic send(input int d, input logic [7:0] b, input logic brk);
        @(posedge clk); #1;
        case (d)
            0: begin b0.rx_valid = 1'b1; b0.rx_data = b; b0.rx_break = brk; end
            1: begin b1.rx_valid = 1'b1; b1.rx_data = b; b1.rx_break = brk; end
            default: begin b2.rx_valid = 1'b1; b2.rx_data = b; b2.rx_break = brk; end
        endcase
        @(posedge clk); #1;
        clear_rx();
    endtask

    task automatic add(input int d, input logic [7:0] b, input logic we,
                       input logic [7:0] a, input logic [31:0] w);
        vec_t v;
        v.d = d; v.b = b; v.we = we; v.addr = a; v.data = w;
        vt.push_back(v);
    endtask

    initial begin
        logic [7:0] bi;
        resetn = 1'b0;
        le0 = 1'b0; le1 = 1'b0; le2 = 1'b0;
        clear_rx();

        // Nominal load with terminator (u0)
        add(0, 8'h13, 0, 0, 0); add(0, 8'h01, 0, 0, 0); add(0, 8'h01, 0, 0, 0);
        add(0, 8'hFE, 1, 8'd0, 32'hFE01_0113);
        add(0, 8'h23, 0, 0, 0); add(0, 8'h2E, 0, 0, 0); add(0, 8'h81, 0, 0, 0);
        add(0, 8'h00, 1, 8'd1, 32'h0081_2E23);
        add(0, 8'h13, 0, 0, 0); add(0, 8'h04, 0, 0, 0); add(0, 8'h01, 0, 0, 0);
        add(0, 8'h02, 1, 8'd2, 32'h0201_0413);
        add(0, 8'hFF, 0, 0, 0); add(0, 8'hFF, 0, 0, 0); add(0, 8'hFF, 0, 0, 0);
        add(0, 8'hFF, 0, 0, 0);
        // Full memory, DEPTH=4, 17th byte ignored (u1)
        for (int i = 0; i < 17; i++) begin
            bi = 8'(i);
            add(1, bi, (i % 4 == 3) && (i < 16), 8'(i / 4),
                {bi, bi - 8'd1, bi - 8'd2, bi - 8'd3});
        end
        // Two-byte words (u2)
        add(2, 8'h34, 0, 0, 0); add(2, 8'h12, 1, 8'd0, 32'h0000_1234);
        add(2, 8'hFF, 0, 0, 0); add(2, 8'hFF, 0, 0, 0);

        #12;
        chk("reset_outputs", {b0.mem_we, b0.mem_addr, b0.mem_wdata, wd0, er0, ec0, wc0, bz0}, 64'd0);
        resetn = 1'b1;
        le0 = 1'b1; le1 = 1'b1; le2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_load", bz0, 1);

        foreach (vt[k]) begin
            if (vt[k].we) push_wr(vt[k].d, vt[k].addr, vt[k].data);
            send(vt[k].d, vt[k].b, 1'b0);
            chk($sformatf("v%0d_we", k), we_of(vt[k].d), vt[k].we);
        end
        @(posedge clk); #1;
        chk("nom_done", wd0, 1);
        chk("nom_count", wc0, 3);
        chk("nom_busy", bz0, 0);
        chk("full_done", wd1, 1);
        chk("full_count", wc1, 4);
        chk("full_addr_hold", b1.mem_addr, 8'd3);
        chk("full_data_hold", b1.mem_wdata, 32'h0F0E_0D0C);
        chk("w2_done", wd2, 1);
        chk("w2_count", wc2, 1);

        // Timeout after a partial word
        le0 = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", wd0, 0);
        le0 = 1'b1;
        @(posedge clk); #1;
        send(0, 8'hA1, 1'b0);
        send(0, 8'hA2, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        chk("tmo_early", er0, 0);
        @(posedge clk); #1;
        chk("tmo_error", er0, 1);
        chk("tmo_code", ec0, 2);
        le0 = 1'b0;
        @(posedge clk); #1;
        chk("tmo_err_clear", {er0, ec0}, 0);
        le0 = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b0);
        push_wr(0, 8'd0, 32'h4433_2211);
        send(0, 8'h44, 1'b0);
        chk("restart_lat", we_of(0), 1);

        // Break coincident with a byte after one word plus one byte
        send(0, 8'h55, 1'b0);
        send(0, 8'h66, 1'b1);
        chk("brk_we", we_of(0), 0);
        chk("brk_error", er0, 1);
        chk("brk_code", ec0, 1);
        chk("brk_count", wc0, 1);

        // Abort mid-word
        le0 = 1'b0;
        @(posedge clk); #1;
        le0 = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0);
        le0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", bz0, 0);
        chk("abort_status", {wd0, er0, ec0}, 0);
        chk("abort_count", wc0, 0);
        le0 = 1'b1;
        @(posedge clk); #1;
        send(0, 8'hAA, 1'b0); send(0, 8'hBB, 1'b0); send(0, 8'hCC, 1'b0);
        push_wr(0, 8'd0, 32'hDDCC_BBAA);
        send(0, 8'hDD, 1'b0);
        chk("abort_restart_lat", we_of(0), 1);

        // Asynchronous reset mid-word
        send(0, 8'h10, 1'b0); send(0, 8'h20, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("rst_async", {b0.mem_we, b0.mem_addr, b0.mem_wdata, wd0, er0, ec0, wc0, bz0}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h77, 1'b0); send(0, 8'h88, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_write", we_of(0), 0);
        chk("rst_count", wc0, 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
Parametrised byte-to-word instruction loader between the UART receiver and the instruction memory write port. It assembles received bytes little-endian into words and writes each word to consecutive memory addresses. The load ends on a terminator word or when memory is full, and it aborts on a line BREAK or an inter-byte timeout. Completion and error status go to the core-release logic.

Parameters:
WORD_BYTES, 4, bytes per memory word (1..8); WORD_W = 8*WORD_BYTES
ADDR_W, 8, memory address width
DEPTH, 256, words available (1..2**ADDR_W)
TERM_EN, 1, 1 = terminator word ends the load and is not written
TERM_WORD, {WORD_BYTES{8'hFF}}, terminator value
TIMEOUT_CYC, 0, max idle clocks between bytes of a partial word; 0 = disabled

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
load_en  in  1  level; high enables and holds a load session
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
rx_break  in  1  one-cycle strobe, BREAK detected
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  WORD_W  write data
write_done  out  1  load completed successfully (level)
error  out  1  load aborted (level)
err_code  out  2  0 none, 1 break, 2 timeout
word_count  out  ADDR_W+1  words written this session
busy  out  1  state == LOAD

Behaviour:
- Reset (async, resetn low): state IDLE. All outputs are 0. The byte index, timeout counter and assembly register clear. Any partial word is discarded and not written.
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - load_en high -> LOAD on the next edge.
  - On entry to LOAD: word_count, address pointer, byte index, error, err_code and write_done clear.
  - rx_valid and rx_break are ignored in IDLE.
- LOAD, byte capture:
  - On rx_valid, rx_data goes into lane byte_idx. The first byte lands in [7:0], byte k in [8k+7:8k].
  - byte_idx increments and wraps to 0 after WORD_BYTES-1.
- LOAD, word completion (the byte with byte_idx == WORD_BYTES-1):
  - If TERM_EN and the assembled word == TERM_WORD: no write; go to DONE the next cycle.
  - Otherwise, on the next cycle: mem_we = 1 for exactly one cycle, mem_addr = pointer, mem_wdata = word. The pointer and word_count increment in that same cycle.
  - Latency from the last byte's rx_valid to mem_we is 1 clock.
  - If word_count reaches DEPTH after the write: DONE on the following edge.
- LOAD, BREAK: rx_break -> ERR with err_code = 1. The partial word is dropped.
- LOAD, simultaneous rx_valid and rx_break: break wins, the byte is discarded, and no write occurs.
- LOAD, timeout (TIMEOUT_CYC > 0):
  - The counter runs only while byte_idx != 0, and resets on every rx_valid.
  - When it reaches TIMEOUT_CYC: ERR with err_code = 2, partial word dropped.
  - The counter is idle between whole words.
- LOAD, abort: load_en low -> IDLE. Partial word dropped, no write, no error. word_count holds its value.
- DONE: write_done = 1 and holds until load_en goes low, then IDLE. write_done clears on entry to IDLE. Bytes are ignored.
- ERR: error = 1 and err_code hold until load_en goes low, then IDLE with both cleared. Bytes are ignored. Memory already written is not undone.
- Between writes: mem_addr and mem_wdata hold their last written values. mem_we is never asserted outside LOAD.
- DEPTH reached exactly on the terminator: only possible if the terminator is word DEPTH+1, which never arrives because DONE is entered first.

Test Plan:
- Nominal load (defaults): bytes 13 01 01 FE, 23 2E 81 00, 13 04 01 02, FF FF FF FF -> three writes: addr 0 = FE010113, addr 1 = 00812E23, addr 2 = 02010413, each mem_we one clock after the 4th byte. Then write_done = 1, word_count = 3, and no write for the FF word.
- Full memory (DEPTH = 4, TERM_EN = 0): 16 bytes 00..0F -> writes 03020100, 07060504, 0B0A0908, 0F0E0D0C at addresses 0..3, then DONE. A 17th byte is ignored and produces no mem_we.
- Timeout (TIMEOUT_CYC = 100): send 2 bytes, then idle for 100 clocks -> error = 1, err_code = 2, no mem_we. Lowering load_en clears error. A new session then writes its first word at addr 0.
- BREAK: after 1 whole word plus 1 byte, pulse rx_break in the same cycle as rx_valid -> ERR, err_code = 1, word_count = 1, no second write.
- Abort and reset: drop load_en after 2 bytes -> IDLE, no write, busy = 0. In a separate run, assert resetn low mid-word -> all outputs 0 immediately (asynchronous, before the next edge), and no write follows resetn release.
- WORD_BYTES = 2, TERM_WORD = FFFF: bytes 34 12 FF FF -> single write of 1234 at addr 0, then write_done = 1.
